// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: one shared ALU time-multiplexed among NC cores through a
// round-robin IDLE/EXEC/DONE sequencer with registered grant and result strobes.
`default_nettype none

// ---------------------------------------------------------------------------
// Module  : alu
// Brief   : Combinational ALU with signed/unsigned overflow, masked to zero
//           for compare, logical and shift functions.
// Revision: 1.0
// ---------------------------------------------------------------------------
module alu #(
    parameter int N = 32
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic [3:0]   f,
    input  logic         imm,
    output logic [N-1:0] y,
    output logic         ovf
);
    localparam int SW = (N > 1) ? $clog2(N) : 1;

    logic [N-1:0] w_b;
    logic [N:0]   w_sum;
    logic [N:0]   w_diff;

    // Immediate form sign-extends the low half-word of operand B.
    generate
        if (N > 16) begin : g_imm_ext
            assign w_b = imm ? {{(N-16){b[15]}}, b[15:0]} : b;
        end else begin : g_imm_pass
            assign w_b = b;
        end
    endgenerate

    assign w_sum  = {1'b0, a} + {1'b0, w_b};
    assign w_diff = {1'b0, a} - {1'b0, w_b};

    always_comb begin
        y   = '0;
        ovf = 1'b0;
        case (f)
            4'b0000: begin
                y   = w_sum[N-1:0];
                ovf = (a[N-1] == w_b[N-1]) && (w_sum[N-1] != a[N-1]);
            end
            4'b0001: begin
                y   = w_sum[N-1:0];
                ovf = w_sum[N];
            end
            4'b0010: begin
                y   = w_diff[N-1:0];
                ovf = (a[N-1] != w_b[N-1]) && (w_diff[N-1] != a[N-1]);
            end
            4'b0011: begin
                y   = w_diff[N-1:0];
                ovf = w_diff[N];
            end
            4'b0100: y = a & w_b;
            4'b0101: y = a | w_b;
            4'b0110: y = a ^ w_b;
            4'b0111: y = ~(a | w_b);
            4'b1000: y = a << w_b[SW-1:0];
            4'b1001: y = a >> w_b[SW-1:0];
            4'b1010: y = {{(N-1){1'b0}}, ($signed(a) < $signed(w_b))};
            4'b1011: y = {{(N-1){1'b0}}, (a < w_b)};
            default: y = '0;
        endcase
    end
endmodule

// ---------------------------------------------------------------------------
// Module  : alu_share_arbiter
// Brief   : Round-robin sharing of a single ALU among NC requesting cores.
// Revision: 1.0
// ---------------------------------------------------------------------------
module alu_share_arbiter #(
    parameter int N  = 32,
    parameter int NC = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NC-1:0]   req,
    input  logic [NC*N-1:0] a_in,
    input  logic [NC*N-1:0] b_in,
    input  logic [NC*4-1:0] af_in,
    input  logic [NC-1:0]   i_in,
    output logic [NC-1:0]   gnt,
    output logic [NC-1:0]   res_valid,
    output logic [N-1:0]    res,
    output logic            ovf,
    output logic            busy
);
    localparam int PW = $clog2(NC);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        r_state;
    logic [PW-1:0] r_ptr;
    logic [PW-1:0] r_owner;
    logic [N-1:0]  r_a;
    logic [N-1:0]  r_b;
    logic [3:0]    r_af;
    logic          r_i;

    logic          w_found;
    logic [PW-1:0] w_win;
    logic [N-1:0]  w_alu_y;
    logic          w_alu_ovf;

    // First requester scanning upward from the rotating pointer.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        for (int k = 0; k < NC; k++) begin
            if (!w_found && req[(int'(r_ptr) + k) % NC]) begin
                w_found = 1'b1;
                w_win   = PW'((int'(r_ptr) + k) % NC);
            end
        end
    end

    alu #(.N(N)) u_alu (
        .a   (r_a),
        .b   (r_b),
        .f   (r_af),
        .imm (r_i),
        .y   (w_alu_y),
        .ovf (w_alu_ovf)
    );

    assign busy = (r_state != IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= IDLE;
            r_ptr     <= '0;
            r_owner   <= '0;
            r_a       <= '0;
            r_b       <= '0;
            r_af      <= '0;
            r_i       <= 1'b0;
            gnt       <= '0;
            res_valid <= '0;
            res       <= '0;
            ovf       <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    res_valid <= '0;
                    if (w_found) begin
                        r_state <= EXEC;
                        r_owner <= w_win;
                        r_a     <= a_in[w_win*N +: N];
                        r_b     <= b_in[w_win*N +: N];
                        r_af    <= af_in[w_win*4 +: 4];
                        r_i     <= i_in[w_win];
                        gnt     <= {{(NC-1){1'b0}}, 1'b1} << w_win;
                        r_ptr   <= (w_win == PW'(NC-1)) ? '0 : w_win + 1'b1;
                    end else begin
                        gnt <= '0;
                    end
                end
                EXEC: begin
                    r_state   <= DONE;
                    gnt       <= '0;
                    res       <= w_alu_y;
                    ovf       <= w_alu_ovf;
                    res_valid <= {{(NC-1){1'b0}}, 1'b1} << r_owner;
                end
                DONE: begin
                    r_state   <= IDLE;
                    res_valid <= '0;
                end
                default: begin
                    r_state   <= IDLE;
                    gnt       <= '0;
                    res_valid <= '0;
                end
            endcase
        end
    end
endmodule

`default_nettype wire

// File: tb/tb_alu_share_arbiter.sv
// tb_alu_share_arbiter: directed vectors with hand-computed results for the
// shared-ALU arbiter (single ops, overflow, compare, rotation, reset mid-op).
`default_nettype none

module tb_alu_share_arbiter;
    localparam int N  = 32;
    localparam int NC = 4;

    logic            clk = 1'b0;
    logic            reset;
    logic [NC-1:0]   req;
    logic [NC*N-1:0] a_in;
    logic [NC*N-1:0] b_in;
    logic [NC*4-1:0] af_in;
    logic [NC-1:0]   i_in;
    logic [NC-1:0]   gnt;
    logic [NC-1:0]   res_valid;
    logic [N-1:0]    res;
    logic            ovf;
    logic            busy;

    int compared   = 0;
    int mismatched = 0;

    alu_share_arbiter #(.N(N), .NC(NC)) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .a_in      (a_in),
        .b_in      (b_in),
        .af_in     (af_in),
        .i_in      (i_in),
        .gnt       (gnt),
        .res_valid (res_valid),
        .res       (res),
        .ovf       (ovf),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_core(input int k, input logic [N-1:0] a, input logic [N-1:0] b,
                            input logic [3:0] af, input logic imm);
        a_in[k*N +: N]  = a;
        b_in[k*N +: N]  = b;
        af_in[k*4 +: 4] = af;
        i_in[k]         = imm;
    endtask

    // One isolated operation: grant, result, then return to idle.
    task automatic do_op(input string tag, input int k, input logic [N-1:0] a,
                         input logic [N-1:0] b, input logic [3:0] af, input logic imm,
                         input logic [N-1:0] exp_res, input logic exp_ovf);
        logic [NC-1:0] oh;
        oh  = 4'b0001 << k;
        req = '0;
        set_core(k, a, b, af, imm);
        req[k] = 1'b1;
        step();
        chk({tag, "_gnt"}, 64'(gnt), 64'(oh));
        chk({tag, "_busy"}, 64'(busy), 64'd1);
        chk({tag, "_rv_exec"}, 64'(res_valid), 64'd0);
        req = '0;
        step();
        chk({tag, "_rv"}, 64'(res_valid), 64'(oh));
        chk({tag, "_res"}, 64'(res), 64'(exp_res));
        chk({tag, "_ovf"}, 64'(ovf), 64'(exp_ovf));
        chk({tag, "_gnt_done"}, 64'(gnt), 64'd0);
        step();
        chk({tag, "_rv_idle"}, 64'(res_valid), 64'd0);
        chk({tag, "_busy_idle"}, 64'(busy), 64'd0);
        chk({tag, "_res_hold"}, 64'(res), 64'(exp_res));
    endtask

    initial begin
        reset = 1'b1;
        req   = '0;
        a_in  = '0;
        b_in  = '0;
        af_in = '0;
        i_in  = '0;
        step();
        step();
        chk("rst_gnt", 64'(gnt), 64'd0);
        chk("rst_rv", 64'(res_valid), 64'd0);
        chk("rst_res", 64'(res), 64'd0);
        chk("rst_ovf", 64'(ovf), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        reset = 1'b0;
        step();

        do_op("add_c2", 2, 32'd5, 32'd3, 4'b0000, 1'b0, 32'd8, 1'b0);
        do_op("ovf_s", 0, 32'h7FFF_FFFF, 32'd1, 4'b0000, 1'b0, 32'h8000_0000, 1'b1);
        do_op("ovf_u", 0, 32'h7FFF_FFFF, 32'd1, 4'b0001, 1'b0, 32'h8000_0000, 1'b0);
        do_op("slt_t", 1, 32'd3, 32'd7, 4'b1010, 1'b0, 32'd1, 1'b0);
        do_op("slt_f", 1, 32'd7, 32'd3, 4'b1010, 1'b0, 32'd0, 1'b0);
        do_op("sub", 3, 32'd5, 32'd7, 4'b0010, 1'b0, 32'hFFFF_FFFE, 1'b0);
        do_op("and", 0, 32'h0000_F0F0, 32'h0000_FF00, 4'b0100, 1'b0, 32'h0000_F000, 1'b0);
        do_op("imm", 1, 32'd10, 32'h0001_FFFF, 4'b0000, 1'b1, 32'd9, 1'b0);

        // Operand change after grant must not reach the result.
        req = '0;
        set_core(3, 32'd100, 32'd20, 4'b0000, 1'b0);
        req[3] = 1'b1;
        step();
        chk("hold_gnt", 64'(gnt), 64'b1000);
        set_core(3, 32'd555, 32'd999, 4'b0010, 1'b0);
        req = '0;
        step();
        chk("hold_rv", 64'(res_valid), 64'b1000);
        chk("hold_res", 64'(res), 64'd120);
        step();

        // All four cores held from reset: strict rotation 0,1,2,3,0.
        reset = 1'b1;
        #1;
        for (int k = 0; k < NC; k++)
            set_core(k, 32'(k + 1), 32'(10 * k), 4'b0000, 1'b0);
        req = 4'b1111;
        step();
        reset = 1'b0;
        for (int n = 0; n < 5; n++) begin
            step();
            chk($sformatf("rot%0d_gnt", n), 64'(gnt), 64'(4'b0001 << (n % 4)));
            step();
            chk($sformatf("rot%0d_rv", n), 64'(res_valid), 64'(4'b0001 << (n % 4)));
            chk($sformatf("rot%0d_res", n), 64'(res), 64'((n % 4) + 1 + 10 * (n % 4)));
            step();
            chk($sformatf("rot%0d_idle", n), 64'({gnt, res_valid}), 64'd0);
        end

        // Reset during EXEC abandons the op; pointer returns to core 0.
        req = 4'b1100;
        step();
        chk("rmid_gnt", 64'(gnt), 64'b0100);
        reset = 1'b1;
        #1;
        chk("rmid_outs", 64'({gnt, res_valid, ovf, busy}), 64'd0);
        chk("rmid_res", 64'(res), 64'd0);
        step();
        chk("rmid_rv_held", 64'(res_valid), 64'd0);
        reset = 1'b0;
        step();
        chk("rmid_regnt", 64'(gnt), 64'b0100);
        chk("rmid_rv_none", 64'(res_valid), 64'd0);
        req = '0;
        step();
        chk("rmid_rv", 64'(res_valid), 64'b0100);
        chk("rmid_res2", 64'(res), 64'd23);
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

`default_nettype wire
